// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding and frame/baud constants
// used by the transmit controller and the future receive block.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int UART_FRAME_BITS       = 10;
    localparam int UART_BAUD_DIV_DEFAULT = 5208;

endpackage

// File: rtl/uart_tx_fifo.sv
// Parameterised synchronous FIFO buffering CPU bytes for the UART transmitter.
// A write into a full FIFO is only taken when a read happens in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_s;
    logic             pop_s;

    assign empty   = (count_r == (AW+1)'(0));
    assign full    = (count_r == (AW+1)'(DEPTH));
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];
    assign pop_s   = rd_en && !empty;
    assign push_s  = wr_en && (!full || pop_s);

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: FIFO-buffered CPU bytes sent as 8N1 frames,
// with busy/full/overflow/done status for the peripheral register file.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = UART_BAUD_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_ovf,
    output logic              tx_full,
    output logic              tx_busy,
    output logic              tx_ovf,
    output logic              tx_done,
    output logic              UART_TX
);

    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_W - 1);

    tx_state_e         state_r, state_s;
    logic [15:0]       baud_cnt_r, baud_cnt_s;
    logic [2:0]        bit_idx_r, bit_idx_s;
    logic [DATA_W-1:0] shift_r, shift_s;
    logic              tx_r, tx_s;
    logic              done_r, done_s;
    logic              ovf_r, ovf_s;
    logic              pop_s;
    logic              term_s;
    logic              drop_s;
    logic [DATA_W-1:0] fifo_rd_data_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign term_s = (baud_cnt_r == BAUD_LAST);
    assign drop_s = wr_en && fifo_full_s && !pop_s;

    // Frame sequencing, baud pacing and next line level.
    always_comb begin
        state_s    = state_r;
        baud_cnt_s = baud_cnt_r;
        bit_idx_s  = bit_idx_r;
        shift_s    = shift_r;
        done_s     = 1'b0;
        pop_s      = 1'b0;

        if (state_r == IDLE) begin
            baud_cnt_s = 16'd0;
        end else if (term_s) begin
            baud_cnt_s = 16'd0;
        end else begin
            baud_cnt_s = baud_cnt_r + 16'd1;
        end

        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = fifo_rd_data_s;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (term_s) begin
                    state_s   = DATA;
                    bit_idx_s = 3'd0;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (term_s) begin
                    shift_s   = {1'b0, shift_r[DATA_W-1:1]};
                    bit_idx_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == LAST_BIT) begin
                        state_s = STOP;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (term_s) begin
                    done_s = 1'b1;
                    // Chain straight into the next frame when more data waits.
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_s = fifo_rd_data_s;
                        state_s = START;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[0];
            default: tx_s = 1'b1;
        endcase

        if (drop_s) begin
            ovf_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = ovf_r;
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            baud_cnt_r <= 16'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= {DATA_W{1'b0}};
            tx_r       <= 1'b1;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_idx_r  <= bit_idx_s;
            shift_r    <= shift_s;
            tx_r       <= tx_s;
            done_r     <= done_s;
            ovf_r      <= ovf_s;
        end
    end

    assign UART_TX = tx_r;
    assign tx_done = done_r;
    assign tx_ovf  = ovf_r;
    assign tx_full = fifo_full_s;
    assign tx_busy = (state_r != IDLE) || (fifo_count_s != CNT_W'(0));

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl at BAUD_DIV=4, FIFO_DEPTH=4, with an
// independent line receiver and tx_done pulse counter.
module tb_uart_tx_ctrl;

    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_ovf = 1'b0;
    logic       tx_full, tx_busy, tx_ovf, tx_done, UART_TX;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    logic [7:0] rxq [$];

    uart_tx_ctrl #(.BAUD_DIV(BD), .FIFO_DEPTH(4), .DATA_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .clr_ovf (clr_ovf),
        .tx_full (tx_full),
        .tx_busy (tx_busy),
        .tx_ovf  (tx_ovf),
        .tx_done (tx_done),
        .UART_TX (UART_TX)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
    end

    // Line receiver: samples mid-bit, drops frames hit by reset or bad stop bit.
    initial begin
        int off;
        logic [7:0] b;
        logic bad;
        forever begin
            @(posedge clk); #2;
            if (!reset && UART_TX === 1'b0) begin
                off = 0; bad = 1'b0; b = 8'h00;
                for (int j = 0; j < 8; j++) begin
                    while (off < BD*(j+1) + BD/2) begin
                        @(posedge clk); #2; off++;
                        if (reset) bad = 1'b1;
                    end
                    b[j] = UART_TX;
                end
                while (off < BD*9 + BD/2) begin
                    @(posedge clk); #2; off++;
                    if (reset) bad = 1'b1;
                end
                if (UART_TX !== 1'b1) bad = 1'b1;
                if (!bad) rxq.push_back(b);
                while (off < BD*10 - 1) begin
                    @(posedge clk); #2; off++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Called at the first START cycle; ends just after the final stop-bit edge.
    task automatic frame_check(input logic [7:0] data);
        logic [9:0] f;
        f = {1'b1, data, 1'b0};
        for (int k = 0; k < 10*BD; k++) begin
            chk("frame_bit", UART_TX, f[k/BD]);
            if (k > 0) chk("done_low", tx_done, 1'b0);
            tick();
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (tx_busy && n < max_cycles) begin
            tick();
            n++;
        end
        chk("idle_wait", tx_busy, 1'b0);
        repeat (3) tick();
    endtask

    initial begin
        int base, dbase, nrx;

        // Reset state
        tick(); tick();
        chk("rst_tx", UART_TX, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_full", tx_full, 1'b0);
        chk("rst_ovf", tx_ovf, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        reset = 1'b0;
        tick(); tick();

        // Single 0x55 frame
        wr_en = 1'b1; wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        chk("t1_tx_idle", UART_TX, 1'b1);
        chk("t1_busy", tx_busy, 1'b1);
        tick();
        frame_check(8'h55);
        chk("t1_done", tx_done, 1'b1);
        chk("t1_busy_fall", tx_busy, 1'b0);
        chk("t1_tx_high", UART_TX, 1'b1);
        tick();
        chk("t1_done_once", tx_done, 1'b0);
        repeat (3) tick();

        // Back-to-back 0xA3, 0x0F
        wr_en = 1'b1; wr_data = 8'hA3;
        tick();
        wr_data = 8'h0F;
        tick();
        wr_en = 1'b0;
        frame_check(8'hA3);
        chk("t2_done1", tx_done, 1'b1);
        frame_check(8'h0F);
        chk("t2_done2", tx_done, 1'b1);
        chk("t2_busy_fall", tx_busy, 1'b0);
        repeat (3) tick();

        // Six writes into a depth-4 FIFO; then clear/drop priority
        base = rxq.size(); dbase = done_cnt;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'h11 + 8'(i);
            tick();
            if (i == 4) begin
                chk("t3_full_at5", tx_full, 1'b1);
                chk("t3_ovf_at5", tx_ovf, 1'b0);
            end
        end
        chk("t3_full", tx_full, 1'b1);
        chk("t3_ovf", tx_ovf, 1'b1);
        wr_data = 8'h77; clr_ovf = 1'b1;
        tick();
        chk("t5_set_wins", tx_ovf, 1'b1);
        chk("t5_full", tx_full, 1'b1);
        wr_en = 1'b0;
        tick();
        chk("t5_clr", tx_ovf, 1'b0);
        clr_ovf = 1'b0;
        wait_idle(400);
        nrx = rxq.size() - base;
        chk("t3_frames", nrx, 5);
        chk("t3_dones", done_cnt - dbase, 5);
        for (int i = 0; i < 5 && i < nrx; i++) chk("t3_byte", rxq[base+i], 8'h11 + 8'(i));

        // Write while full coinciding with the STOP-terminal pop
        base = rxq.size(); dbase = done_cnt;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'h21 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        repeat (36) tick();
        chk("t4_full_pre", tx_full, 1'b1);
        chk("t4_done_pre", tx_done, 1'b0);
        wr_en = 1'b1; wr_data = 8'h26;
        tick();
        wr_en = 1'b0;
        chk("t4_pop_done", tx_done, 1'b1);
        chk("t4_full_kept", tx_full, 1'b1);
        chk("t4_no_ovf", tx_ovf, 1'b0);
        wait_idle(400);
        nrx = rxq.size() - base;
        chk("t4_frames", nrx, 6);
        chk("t4_dones", done_cnt - dbase, 6);
        for (int i = 0; i < 6 && i < nrx; i++) chk("t4_byte", rxq[base+i], 8'h21 + 8'(i));

        // Reset in the middle of DATA bit 3 with two bytes queued
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'h31 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        repeat (17) tick();
        chk("t6_bit3", UART_TX, 1'b0);
        chk("t6_busy_pre", tx_busy, 1'b1);
        base = rxq.size(); dbase = done_cnt;
        reset = 1'b1;
        #1;
        chk("t6_tx", UART_TX, 1'b1);
        chk("t6_busy", tx_busy, 1'b0);
        chk("t6_full", tx_full, 1'b0);
        chk("t6_done", tx_done, 1'b0);
        tick(); tick();
        reset = 1'b0;
        repeat (120) tick();
        chk("t6_tx_after", UART_TX, 1'b1);
        chk("t6_busy_after", tx_busy, 1'b0);
        chk("t6_no_done", done_cnt - dbase, 0);
        chk("t6_no_frames", rxq.size() - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
